// File: rtl/bsr_pkg.sv
// Shared definitions for the BSR matrix readback streamer and its receiver:
// FSM states, CRC32 constants and the byte-wise CRC update.
package bsr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_RP_RD,
        ST_RP_TX,
        ST_CI_RD,
        ST_CI_TX,
        ST_BK_RD,
        ST_BK_TX,
        ST_CRC_TX,
        ST_DONE
    } bsr_state_e;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam int          BLOCK_WORDS = 16;
    localparam int          HDR_BYTES   = 12;
    localparam int          HDR_WORDS   = HDR_BYTES / 4;

    // Data bits enter LSB-first while the register shifts left (non-reflected register).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[31] ^ data[i]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/bsr_word_serializer.sv
// Breaks a 1/2/4-byte word into bytes LSB-first under valid/ready; the first
// byte is forwarded straight from i_word in the load cycle so no bubble is added.
module bsr_word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [2:0]  i_nbytes,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_fire,
    output logic        o_last,
    output logic        o_active
);

    logic [31:0] r_word;
    logic [2:0]  r_cnt;
    logic        r_valid;
    logic [31:0] w_word;
    logic [2:0]  w_cnt;

    always_comb begin
        w_word   = r_valid ? r_word : i_word;
        w_cnt    = r_valid ? r_cnt  : i_nbytes;
        o_valid  = r_valid | i_load;
        o_data   = o_valid ? w_word[7:0] : 8'h00;
        o_last   = o_valid && (w_cnt == 3'd1);
        o_fire   = o_valid && i_ready;
        o_active = r_valid;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= 32'h0;
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
        end else if (o_fire) begin
            r_word  <= {8'h00, w_word[31:8]};
            r_cnt   <= w_cnt - 3'd1;
            r_valid <= (w_cnt != 3'd1);
        end else if (i_load && !r_valid) begin
            r_word  <= i_word;
            r_cnt   <= i_nbytes;
            r_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/bsr_readback.sv
// Streams a BSR sparse matrix (header, row_ptr, col_idx, block words, CRC32)
// from three synchronous BRAMs out over a byte-wide valid/ready UART port.
module bsr_readback
    import bsr_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int BLOCK_AW      = 21,
    parameter int MAX_BLOCKS    = 65536,
    parameter int ROW_PTR_DEPTH = 256,
    parameter int ENABLE_CRC    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           cfg_rows,
    input  logic [31:0]           cfg_cols,
    input  logic [31:0]           cfg_blocks,
    output logic                  row_ptr_re,
    output logic [ADDR_WIDTH-1:0] row_ptr_raddr,
    input  logic [31:0]           row_ptr_rdata,
    output logic                  col_idx_re,
    output logic [ADDR_WIDTH-1:0] col_idx_raddr,
    input  logic [15:0]           col_idx_rdata,
    output logic                  block_re,
    output logic [BLOCK_AW-1:0]   block_raddr,
    input  logic [31:0]           block_rdata,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           bytes_sent
);

    bsr_state_e  r_state, w_next, w_after_blocks;
    logic [31:0] r_rows, r_cols, r_blocks, r_idx, r_crc, r_bytes_sent;
    logic        r_error;
    logic [31:0] w_word, w_bk_last;
    logic [2:0]  w_nbytes;
    logic [7:0]  w_tx_data;
    logic        w_legal, w_tx_state, w_load, w_fire, w_last, w_active;
    logic        w_word_done, w_sect_end;

    assign w_legal        = (cfg_blocks <= 32'(MAX_BLOCKS)) && (cfg_rows <= 32'(ROW_PTR_DEPTH - 1));
    assign w_bk_last      = r_blocks * 32'(BLOCK_WORDS) - 32'd1;
    assign w_after_blocks = (ENABLE_CRC != 0) ? ST_CRC_TX : ST_DONE;
    assign w_word_done    = w_fire && w_last;
    // A TX state with an idle serializer has just been entered: rdata is valid now.
    assign w_load         = w_tx_state && !w_active;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_word     = 32'h0;
        w_nbytes   = 3'd4;
        w_tx_state = 1'b0;
        w_sect_end = 1'b0;
        row_ptr_re = 1'b0;
        col_idx_re = 1'b0;
        block_re   = 1'b0;
        unique case (r_state)
            ST_IDLE: if (start && w_legal) w_next = ST_HDR;
            ST_HDR: begin
                w_tx_state = 1'b1;
                w_word     = (r_idx == 32'd0) ? r_rows : (r_idx == 32'd1) ? r_cols : r_blocks;
                w_sect_end = (r_idx == 32'(HDR_WORDS - 1));
                if (w_word_done && w_sect_end) w_next = ST_RP_RD;
            end
            ST_RP_RD: begin
                row_ptr_re = 1'b1;
                w_next     = ST_RP_TX;
            end
            ST_RP_TX: begin
                w_tx_state = 1'b1;
                w_word     = row_ptr_rdata;
                w_sect_end = (r_idx == r_rows);
                if (w_word_done) begin
                    if (!w_sect_end)            w_next = ST_RP_RD;
                    else if (r_blocks != 32'd0) w_next = ST_CI_RD;
                    else                        w_next = w_after_blocks;
                end
            end
            ST_CI_RD: begin
                col_idx_re = 1'b1;
                w_next     = ST_CI_TX;
            end
            ST_CI_TX: begin
                w_tx_state = 1'b1;
                w_word     = {16'h0, col_idx_rdata};
                w_nbytes   = 3'd2;
                w_sect_end = (r_idx == r_blocks - 32'd1);
                if (w_word_done) w_next = w_sect_end ? ST_BK_RD : ST_CI_RD;
            end
            ST_BK_RD: begin
                block_re = 1'b1;
                w_next   = ST_BK_TX;
            end
            ST_BK_TX: begin
                w_tx_state = 1'b1;
                w_word     = block_rdata;
                w_sect_end = (r_idx == w_bk_last);
                if (w_word_done) w_next = w_sect_end ? w_after_blocks : ST_BK_RD;
            end
            ST_CRC_TX: begin
                w_tx_state = 1'b1;
                w_word     = ~r_crc;
                w_sect_end = 1'b1;
                if (w_word_done) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rows       <= 32'h0;
            r_cols       <= 32'h0;
            r_blocks     <= 32'h0;
            r_idx        <= 32'h0;
            r_crc        <= CRC_INIT;
            r_bytes_sent <= 32'h0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                if (w_legal) begin
                    r_rows       <= cfg_rows;
                    r_cols       <= cfg_cols;
                    r_blocks     <= cfg_blocks;
                    r_idx        <= 32'h0;
                    r_crc        <= CRC_INIT;
                    r_bytes_sent <= 32'h0;
                    r_error      <= 1'b0;
                end else begin
                    r_error <= 1'b1;
                end
            end
            if (w_fire) begin
                r_bytes_sent <= r_bytes_sent + 32'd1;
                if (r_state inside {ST_RP_TX, ST_CI_TX, ST_BK_TX})
                    r_crc <= crc32_byte(r_crc, w_tx_data);
            end
            if (w_word_done) r_idx <= w_sect_end ? 32'h0 : r_idx + 32'd1;
        end
    end

    bsr_word_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_word   (w_word),
        .i_nbytes (w_nbytes),
        .i_ready  (uart_tx_ready),
        .o_data   (w_tx_data),
        .o_valid  (uart_tx_valid),
        .o_fire   (w_fire),
        .o_last   (w_last),
        .o_active (w_active)
    );

    assign uart_tx_data  = w_tx_data;
    assign row_ptr_raddr = r_idx[ADDR_WIDTH-1:0];
    assign col_idx_raddr = r_idx[ADDR_WIDTH-1:0];
    assign block_raddr   = r_idx[BLOCK_AW-1:0];
    assign busy          = !(r_state inside {ST_IDLE, ST_DONE});
    assign done          = (r_state == ST_DONE);
    assign error         = r_error;
    assign bytes_sent    = r_bytes_sent;

endmodule

// File: tb/tb_bsr_readback.sv
// Directed bench for bsr_readback: a CRC-enabled and a CRC-disabled instance
// share BRAM contents; one monitor captures whichever instance is selected.
module tb_bsr_readback;

    logic        clk = 1'b0;
    logic        rst_n, start, ready, sel, stall_en, stall_done;
    logic [31:0] cfg_rows, cfg_cols, cfg_blocks;

    logic        rp_re [2], ci_re [2], bk_re [2], tx_valid [2], busy_o [2], done_o [2], err_o [2];
    logic [15:0] rp_a [2], ci_a [2];
    logic [20:0] bk_a [2];
    logic [31:0] rp_rd [2], bk_rd [2], bsent [2];
    logic [15:0] ci_rd [2];
    logic [7:0]  tx_data [2];
    logic        start0, start1;

    logic [31:0] rp_mem [256];
    logic [15:0] ci_mem [16];
    logic [31:0] bk_mem [16];

    logic [7:0]  cap_q [$];
    logic [7:0]  exp_q [$];
    logic [31:0] m_crc;
    int          valid_cnt, done_cnt, ci_cnt, bk_cnt;
    int          n_vec = 0, n_bad = 0;

    logic        m_valid, m_busy, m_done, m_err, m_ci_re, m_bk_re;
    logic [7:0]  m_data;
    logic [31:0] m_bytes;

    always #5 clk = ~clk;

    assign start0  = start && !sel;
    assign start1  = start && sel;
    assign m_valid = tx_valid[sel];
    assign m_data  = tx_data[sel];
    assign m_busy  = busy_o[sel];
    assign m_done  = done_o[sel];
    assign m_err   = err_o[sel];
    assign m_ci_re = ci_re[sel];
    assign m_bk_re = bk_re[sel];
    assign m_bytes = bsent[sel];

    bsr_readback #(.ENABLE_CRC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_blocks(cfg_blocks),
        .row_ptr_re(rp_re[0]), .row_ptr_raddr(rp_a[0]), .row_ptr_rdata(rp_rd[0]),
        .col_idx_re(ci_re[0]), .col_idx_raddr(ci_a[0]), .col_idx_rdata(ci_rd[0]),
        .block_re(bk_re[0]), .block_raddr(bk_a[0]), .block_rdata(bk_rd[0]),
        .uart_tx_data(tx_data[0]), .uart_tx_valid(tx_valid[0]), .uart_tx_ready(ready),
        .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0]), .bytes_sent(bsent[0])
    );

    bsr_readback #(.ENABLE_CRC(0)) dut_nocrc (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_blocks(cfg_blocks),
        .row_ptr_re(rp_re[1]), .row_ptr_raddr(rp_a[1]), .row_ptr_rdata(rp_rd[1]),
        .col_idx_re(ci_re[1]), .col_idx_raddr(ci_a[1]), .col_idx_rdata(ci_rd[1]),
        .block_re(bk_re[1]), .block_raddr(bk_a[1]), .block_rdata(bk_rd[1]),
        .uart_tx_data(tx_data[1]), .uart_tx_valid(tx_valid[1]), .uart_tx_ready(ready),
        .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1]), .bytes_sent(bsent[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_bram
        always @(posedge clk) begin
            if (rp_re[g]) rp_rd[g] <= rp_mem[rp_a[g][7:0]];
            if (ci_re[g]) ci_rd[g] <= ci_mem[ci_a[g][3:0]];
            if (bk_re[g]) bk_rd[g] <= bk_mem[bk_a[g][3:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++) begin
            if (x[31] ^ b[i]) x = {x[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              x = {x[30:0], 1'b0};
        end
        return x;
    endfunction

    task automatic push_word(input logic [31:0] w, input int n, input bit cov);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(w[8*i +: 8]);
            if (cov) m_crc = crc_model(m_crc, w[8*i +: 8]);
        end
    endtask

    task automatic build_exp(input int rows, input int blocks, input bit crc_en);
        exp_q.delete();
        m_crc = 32'hFFFF_FFFF;
        push_word(32'(rows), 4, 1'b0);
        push_word(32'd1, 4, 1'b0);
        push_word(32'(blocks), 4, 1'b0);
        for (int i = 0; i <= rows; i++)       push_word(rp_mem[i], 4, 1'b1);
        for (int i = 0; i < blocks; i++)      push_word({16'h0, ci_mem[i]}, 2, 1'b1);
        for (int i = 0; i < 16 * blocks; i++) push_word(bk_mem[i], 4, 1'b1);
        if (crc_en) push_word(~m_crc, 4, 1'b0);
    endtask

    task automatic clear_mon();
        cap_q.delete();
        valid_cnt = 0; done_cnt = 0; ci_cnt = 0; bk_cnt = 0;
    endtask

    task automatic pulse_start(input int rows, input int blocks);
        cfg_rows = 32'(rows); cfg_cols = 32'd1; cfg_blocks = 32'(blocks);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_case(input string nm, input int rows, input int blocks, input bit crc_off, input int exp_len);
        int bad;
        sel = crc_off;
        clear_mon();
        build_exp(rows, blocks, !crc_off);
        pulse_start(rows, blocks);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        check({nm, ".done_seen"}, 32'(done_cnt), 32'd1);
        check({nm, ".busy_at_done"}, 32'(m_busy), 32'd0);
        check({nm, ".len"}, 32'(cap_q.size()), 32'(exp_len));
        bad = 0;
        for (int i = 0; i < exp_len; i++)
            if (i >= cap_q.size() || i >= exp_q.size() || cap_q[i] !== exp_q[i]) bad++;
        check({nm, ".stream_bad_bytes"}, 32'(bad), 32'd0);
        repeat (4) @(negedge clk);
        check({nm, ".bytes_sent"}, m_bytes, 32'(exp_len));
        check({nm, ".one_done"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rp_mem[i] = 32'h0;
        rp_mem[1] = 32'd1; rp_mem[2] = 32'd1; rp_mem[3] = 32'd1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(4 * i);
            ci_mem[i] = 16'h0;
            bk_mem[i] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid && ready) cap_q.push_back(m_data);
        if (m_valid) valid_cnt++;
        if (m_done)  done_cnt++;
        if (m_ci_re) ci_cnt++;
        if (m_bk_re) bk_cnt++;
    end

    // Holds ready low for 5 cycles when block byte 20 (stream byte 50) is offered.
    initial begin
        ready = 1'b1;
        stall_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_en && !stall_done && cap_q.size() == 50 && m_valid) begin
                ready = 1'b0;
                stall_done = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall.data", 32'(m_data), 32'h24);
                    check("stall.valid", 32'(m_valid), 32'd1);
                    @(posedge clk); #1;
                end
                ready = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr_ref [12];
        int bad;
        hdr_ref = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; stall_en = 1'b0;
        cfg_rows = 32'h0; cfg_cols = 32'h0; cfg_blocks = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(tx_valid[0]), 32'd0);
        check("rst.data", 32'(tx_data[0]), 32'd0);
        check("rst.busy_done_err", {29'd0, busy_o[0], done_o[0], err_o[0]}, 32'd0);
        check("rst.re", {29'd0, rp_re[0], ci_re[0], bk_re[0]}, 32'd0);
        check("rst.bytes_sent", bsent[0], 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_case("basic", 3, 1, 1'b0, 98);
        bad = 0;
        for (int i = 0; i < 12; i++) if (i >= cap_q.size() || cap_q[i] !== hdr_ref[i]) bad++;
        check("basic.header", 32'(bad), 32'd0);
        check("basic.crc", (cap_q.size() == 98) ? {cap_q[97], cap_q[96], cap_q[95], cap_q[94]} : 32'h0, ~m_crc);

        stall_en = 1'b1;
        run_case("stall", 3, 1, 1'b0, 98);
        check("stall.hit", 32'(stall_done), 32'd1);
        stall_en = 1'b0;

        run_case("empty", 0, 0, 1'b0, 20);
        check("empty.col_idx_re", 32'(ci_cnt), 32'd0);
        check("empty.block_re", 32'(bk_cnt), 32'd0);

        clear_mon();
        pulse_start(3, 65537);
        repeat (20) @(negedge clk);
        check("err_blk.error", 32'(m_err), 32'd1);
        check("err_blk.busy", 32'(m_busy), 32'd0);
        check("err_blk.valid_cnt", 32'(valid_cnt), 32'd0);
        check("err_blk.done_cnt", 32'(done_cnt), 32'd0);
        clear_mon();
        pulse_start(256, 1);
        repeat (20) @(negedge clk);
        check("err_rows.error", 32'(m_err), 32'd1);
        check("err_rows.valid_cnt", 32'(valid_cnt), 32'd0);
        run_case("after_err", 3, 1, 1'b0, 98);
        check("after_err.error", 32'(m_err), 32'd0);

        clear_mon();
        pulse_start(3, 1);
        for (int i = 0; i < 2000 && cap_q.size() < 40; i++) begin
            @(posedge clk); #1;
        end
        check("abort.reached40", 32'(cap_q.size()), 32'd40);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.valid", 32'(tx_valid[0]), 32'd0);
        check("abort.data", 32'(tx_data[0]), 32'd0);
        check("abort.busy_done_err", {29'd0, busy_o[0], done_o[0], err_o[0]}, 32'd0);
        check("abort.re", {29'd0, rp_re[0], ci_re[0], bk_re[0]}, 32'd0);
        check("abort.bytes_sent", bsent[0], 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_case("restart", 3, 1, 1'b0, 98);

        run_case("nocrc", 3, 1, 1'b1, 94);
        check("nocrc.last_byte", (cap_q.size() == 94) ? 32'(cap_q[93]) : 32'hFFFF, 32'h4F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bsr_readback.md
BSR_READBACK -- requirements
Module: bsr_readback

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, row_ptr/col_idx read-address width.
REQ-002 Parameter BLOCK_AW, default 21, block BRAM word-address width.
REQ-003 Parameter MAX_BLOCKS, default 65536, largest legal cfg_blocks.
REQ-004 Parameter ROW_PTR_DEPTH, default 256, row_ptr entries; legal cfg_rows <= ROW_PTR_DEPTH-1.
REQ-005 Parameter ENABLE_CRC, default 1, append CRC32 trailer when 1.
REQ-006 Ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-007 Ports: start in 1 one-cycle request; cfg_rows/cfg_cols/cfg_blocks in 32 each, header fields.
REQ-008 Ports: row_ptr_re out 1; row_ptr_raddr out ADDR_WIDTH; row_ptr_rdata in 32.
REQ-009 Ports: col_idx_re out 1; col_idx_raddr out ADDR_WIDTH; col_idx_rdata in 16.
REQ-010 Ports: block_re out 1; block_raddr out BLOCK_AW; block_rdata in 32.
REQ-011 Ports: uart_tx_data out 8; uart_tx_valid out 1; uart_tx_ready in 1.
REQ-012 Ports: busy out 1; done out 1; error out 1; bytes_sent out 32.

Function
REQ-013 All BRAM reads synchronous: rdata valid exactly one cycle after re/raddr; re high for one cycle per word.
REQ-014 Byte stream order: header (rows, cols, blocks), row_ptr[0..cfg_rows], col_idx[0..cfg_blocks-1], block words 0..16*cfg_blocks-1, CRC; every multi-byte value LSB-first.
REQ-015 Byte sizes: header 12, row_ptr 4 each, col_idx 2 each, block word 4, CRC 4.
REQ-016 States: IDLE, HDR, RP_RD, RP_TX, CI_RD, CI_TX, BK_RD, BK_TX, CRC_TX, DONE; *_RD issues one read, next *_TX captures rdata and emits bytes.
REQ-017 Byte transfer occurs only on uart_tx_valid && uart_tx_ready; data and valid held stable while ready is low.
REQ-018 CRC32: poly 0x04C11DB7, init 0xFFFFFFFF, bits processed LSB-first per byte (shift left, XOR when crc[31]^d[0]), trailer = ~crc; CRC covers all bytes after header, excluding trailer.
REQ-019 ENABLE_CRC=0: CRC_TX skipped, DONE follows last block byte.
REQ-020 cfg_blocks=0: CI and BK sections skipped; row_ptr still sends cfg_rows+1 entries.
REQ-021 start in IDLE with cfg_blocks>MAX_BLOCKS or cfg_rows>ROW_PTR_DEPTH-1: error=1, busy=0, no bytes, no done; error clears on next legal start.
REQ-022 Legal start in IDLE: cfg latched, busy=1 next cycle; start while busy ignored.
REQ-023 done: one-cycle pulse in DONE after final byte accepted; busy drops same cycle; return to IDLE.
REQ-024 bytes_sent: cleared on legal start, +1 per accepted byte, holds after done.
REQ-025 Max throughput: one byte per cycle within a word; one-cycle read bubble between words permitted.

Reset
REQ-026 rst_n low: state IDLE; uart_tx_valid, all *_re, busy, done, error = 0; addresses, uart_tx_data, bytes_sent = 0; CRC = 0xFFFFFFFF.
REQ-027 Reset mid-transfer aborts immediately; no partial byte re-sent after release.

Structure
REQ-028 Package bsr_pkg holds state enum, CRC poly/init constants, BLOCK_WORDS=16, header byte count, crc32_byte function (shared with receiver).
REQ-029 One sub-module bsr_word_serializer: loads 32-bit word plus byte count (1/2/4), emits bytes LSB-first under valid/ready, flags last byte.

Verification
REQ-030 rows=3, cols=1, blocks=1, row_ptr={0,1,1,1}, col_idx=0, block bytes 0x10..0x4F -> 98 bytes: 03 00 00 00 01 00 00 00 01 00 00 00, row_ptr, 00 00, 0x10..0x4F, CRC equal to bench model; bytes_sent=98, one done pulse.
REQ-031 Same case, uart_tx_ready low 5 cycles at block byte 20 -> uart_tx_data=0x24 held stable, no byte lost or duplicated.
REQ-032 rows=0, blocks=0, row_ptr[0]=0 -> 20 bytes (12 header, 4 row_ptr, 4 CRC), no col_idx_re/block_re.
REQ-033 blocks=MAX_BLOCKS+1 -> error=1, uart_tx_valid never asserted, done never pulses; later legal start clears error.
REQ-034 rst_n low at byte 40 of REQ-030 case -> all outputs at reset values next cycle; fresh start yields full correct 98-byte stream.
REQ-035 ENABLE_CRC=0, REQ-030 config -> 94 bytes, done after byte 0x4F.
